regfile_sb: RTL and testbench

- Parametrised integer register file for the RISC-V core, next generation of the 32x32 bank.
- Configurable data width and register count; optional hard-wired zero register.
- Writes on the rising edge; reads are asynchronous.
- Adds an asynchronous reset, a per-register pending scoreboard for the pipeline hazard unit, a multi-cycle soft-scrub state machine, and optional write-to-read forwarding.

---
 rtl/regfile_sb.sv | 168 ++++++++++++++++
 tb/tb_regfile_sb.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb -- parametrised integer register file with hazard scoreboard
//
// Two asynchronous read ports and one write port that updates on the rising
// edge. A per-register pending bit tracks outstanding producers for the
// hazard unit. A soft-scrub FSM clears one register per cycle. While the
// scrub runs, writes and issues are ignored.
//
// Optional feature (macro REGFILE_FWD_EN): same-cycle write-to-read bypass
// of write_data onto read_dataN, with rsN_pend masked for that port.
//
// Parameters
//   XLEN     data width of each register
//   NREGS    number of registers (power of two, >= 2)
//   ZERO_R0  1: register 0 reads 0, ignores writes and is never pending
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   rs1, rs2                read addresses
//   read_data1, read_data2  combinational read data
//   rs1_pend, rs2_pend      pending bit of the addressed register
//   rd, write_data          write-back address and data
//   reg_write               write-back enable
//   issue_valid, issue_rd   destination of an instruction issued this cycle
//   scrub_req               one-cycle pulse requesting a soft clear
//   ready                   1 in RUN, 0 while scrubbing
module regfile_sb #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned NREGS   = 32,
   parameter bit          ZERO_R0 = 1'b1,
   localparam int unsigned AW     = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic [XLEN-1:0] read_data1,
   output logic [XLEN-1:0] read_data2,
   output logic            rs1_pend,
   output logic            rs2_pend,
   input  logic [AW-1:0]   rd,
   input  logic [XLEN-1:0] write_data,
   input  logic            reg_write,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rd,
   input  logic            scrub_req,
   output logic            ready
);

   localparam logic [AW-1:0] SC_LAST = AW'(NREGS - 1);

   typedef enum logic {
      RUN   = 1'b0,
      SCRUB = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] pend;
   logic [NREGS-1:0] pend_nxt;
   logic [AW-1:0]    sc;

   logic run;
   logic scrub_done;
   logic wr_en;

   function automatic logic is_zero(input logic [AW-1:0] a);
      return ZERO_R0 && (a == '0);
   endfunction

   // ---------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      run        = (state == RUN);
      scrub_done = (state == SCRUB) && (sc == SC_LAST);
      // A scrub request in the same cycle as a write drops the write.
      wr_en      = run && reg_write && !scrub_req && !is_zero(rd);
      case (state)
         RUN:     if (scrub_req)  state_nxt = SCRUB;
         SCRUB:   if (scrub_done) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   // ---------------------------------------------------------------
   // Register array and scrub counter
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
         sc <= '0;
      end else if (state == SCRUB) begin
         regs[sc] <= '0;
         // Exit happens at SC_LAST, so the counter never wraps.
         sc <= scrub_done ? '0 : sc + AW'(1);
      end else begin
         if (wr_en) begin
            regs[rd] <= write_data;
         end
         if (scrub_req) begin
            sc <= '0;
         end
      end
   end

   // ---------------------------------------------------------------
   // Scoreboard: clear first, then set, so a new producer wins.
   // ---------------------------------------------------------------
   always_comb begin
      pend_nxt = pend;
      if (run && scrub_req) begin
         pend_nxt = '0;
      end else if (run) begin
         if (reg_write) begin
            pend_nxt[rd] = 1'b0;
         end
         if (issue_valid) begin
            pend_nxt[issue_rd] = 1'b1;
         end
      end
      if (ZERO_R0) begin
         pend_nxt[0] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend <= '0;
      end else begin
         pend <= pend_nxt;
      end
   end

   // ---------------------------------------------------------------
   // Read ports
   // ---------------------------------------------------------------
   always_comb begin
      read_data1 = is_zero(rs1) ? '0 : regs[rs1];
      read_data2 = is_zero(rs2) ? '0 : regs[rs2];
      rs1_pend   = run ? pend[rs1] : 1'b0;
      rs2_pend   = run ? pend[rs2] : 1'b0;
`ifdef REGFILE_FWD_EN
      if (run && reg_write && (rd == rs1) && !is_zero(rs1)) begin
         read_data1 = write_data;
         rs1_pend   = 1'b0;
      end
      if (run && reg_write && (rd == rs2) && !is_zero(rs2)) begin
         read_data2 = write_data;
         rs2_pend   = 1'b0;
      end
`endif
   end

   assign ready = run;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb: default instance (32x32,
// zero register) plus a 64-bit, 16-entry instance without a zero register.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        run_clk = 1'b0;
  logic        rst_n = 1'b1;

  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0, issue_rd = '0;
  logic [31:0] write_data = '0;
  logic        reg_write = 1'b0, issue_valid = 1'b0, scrub_req = 1'b0;
  logic [31:0] read_data1, read_data2;
  logic        rs1_pend, rs2_pend, ready;

  logic [3:0]  b_rs1 = '0, b_rs2 = '0, b_rd = '0, b_issue_rd = '0;
  logic [63:0] b_write_data = '0;
  logic        b_reg_write = 1'b0, b_issue_valid = 1'b0, b_scrub_req = 1'b0;
  logic [63:0] b_read_data1, b_read_data2;
  logic        b_rs1_pend, b_rs2_pend, b_ready;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned n;

  regfile_sb u_dut (
    .clk(clk), .rst_n(rst_n),
    .rs1(rs1), .rs2(rs2),
    .read_data1(read_data1), .read_data2(read_data2),
    .rs1_pend(rs1_pend), .rs2_pend(rs2_pend),
    .rd(rd), .write_data(write_data), .reg_write(reg_write),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .scrub_req(scrub_req), .ready(ready)
  );

  regfile_sb #(.XLEN(64), .NREGS(16), .ZERO_R0(1'b0)) u_wide (
    .clk(clk), .rst_n(rst_n),
    .rs1(b_rs1), .rs2(b_rs2),
    .read_data1(b_read_data1), .read_data2(b_read_data2),
    .rs1_pend(b_rs1_pend), .rs2_pend(b_rs2_pend),
    .rd(b_rd), .write_data(b_write_data), .reg_write(b_reg_write),
    .issue_valid(b_issue_valid), .issue_rd(b_issue_rd),
    .scrub_req(b_scrub_req), .ready(b_ready)
  );

  always begin
    #5;
    if (run_clk) clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with the clock stopped
    #1 rst_n = 1'b0;
    #2;
    check("rst_rd1", read_data1, 32'h0);
    check("rst_rd2", read_data2, 32'h0);
    check("rst_ready", ready, 1'b1);
    check("rst_pend", rs1_pend, 1'b0);
    #2 rst_n = 1'b1;
    #2 run_clk = 1'b1;

    // Write to the zero register is dropped
    rd = 5'd0; write_data = 32'hDEADBEEF; reg_write = 1'b1; rs1 = 5'd0;
    tick();
    reg_write = 1'b0;
    #1;
    check("r0_read", read_data1, 32'h0);

    // Write then read, with same-cycle view
    rd = 5'd5; write_data = 32'h12345678; reg_write = 1'b1;
    rs1 = 5'd5; rs2 = 5'd5;
    #1;
`ifdef REGFILE_FWD_EN
    check("same_cycle_rd1", read_data1, 32'h12345678);
`else
    check("same_cycle_rd1", read_data1, 32'h0);
`endif
    tick();
    reg_write = 1'b0;
    #1;
    check("wr5_rd1", read_data1, 32'h12345678);
    check("wr5_rd2", read_data2, 32'h12345678);

    // Scoreboard set
    issue_valid = 1'b1; issue_rd = 5'd7; rs1 = 5'd7; rs2 = 5'd5;
    #1;
    check("pend7_pre", rs1_pend, 1'b0);
    tick();
    issue_valid = 1'b0;
    #1;
    check("pend7_set", rs1_pend, 1'b1);
    check("pend5_clear", rs2_pend, 1'b0);

    // Scoreboard clear by write-back
    rd = 5'd7; write_data = 32'h77; reg_write = 1'b1;
    #1;
`ifdef REGFILE_FWD_EN
    check("pend7_wb_cycle", rs1_pend, 1'b0);
`else
    check("pend7_wb_cycle", rs1_pend, 1'b1);
`endif
    tick();
    reg_write = 1'b0;
    #1;
    check("pend7_cleared", rs1_pend, 1'b0);
    check("rd7_value", read_data1, 32'h77);

    // Set and clear of the same register: set wins
    issue_valid = 1'b1; issue_rd = 5'd7;
    reg_write = 1'b1; rd = 5'd7; write_data = 32'h78;
    tick();
    issue_valid = 1'b0; reg_write = 1'b0;
    #1;
    check("pend7_set_wins", rs1_pend, 1'b1);
    reg_write = 1'b1; rd = 5'd7;
    tick();
    reg_write = 1'b0;

    // Zero register never pending
    issue_valid = 1'b1; issue_rd = 5'd0; rs1 = 5'd0;
    tick();
    issue_valid = 1'b0;
    #1;
    check("pend0_never", rs1_pend, 1'b0);

    // Fill registers 1..31 with their index
    for (int unsigned i = 1; i < 32; i++) begin
      rd = 5'(i); write_data = 32'(i); reg_write = 1'b1;
      tick();
    end
    reg_write = 1'b0;
    rs1 = 5'd1; rs2 = 5'd31;
    #1;
    check("fill_r1", read_data1, 32'd1);
    check("fill_r31", read_data2, 32'd31);
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    issue_valid = 1'b0;
    rs1 = 5'd3;
    #1;
    check("pend3_before_scrub", rs1_pend, 1'b1);

    // Scrub, with a write in the request cycle and writes/issues throughout
    scrub_req = 1'b1; reg_write = 1'b1; rd = 5'd9; write_data = 32'hAAAA;
    tick();
    scrub_req = 1'b0;
    rd = 5'd10; write_data = 32'h5555; issue_valid = 1'b1; issue_rd = 5'd11;
    #1;
    check("scrub_pend_masked", rs1_pend, 1'b0);
    n = 0;
    for (int unsigned g = 0; g < 64 && ready == 1'b0; g++) begin
      n++;
      tick();
    end
    reg_write = 1'b0; issue_valid = 1'b0;
    check("scrub_len32", n, 32);
    for (int unsigned i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(i);
      #1;
      check("post_scrub_data", read_data1, 32'h0);
      check("post_scrub_pend", rs1_pend, 1'b0);
    end

    // Reset during a scrub
    reg_write = 1'b1; rd = 5'd20; write_data = 32'h20;
    tick();
    rd = 5'd31; write_data = 32'h31;
    tick();
    reg_write = 1'b0;
    scrub_req = 1'b1;
    tick();
    scrub_req = 1'b0;
    repeat (9) tick();
    rs1 = 5'd20; rs2 = 5'd31;
    #1;
    check("midscrub_ready", ready, 1'b0);
    check("midscrub_partial", read_data2, 32'h31);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_ready", ready, 1'b1);
    check("midrst_r20", read_data1, 32'h0);
    check("midrst_r31", read_data2, 32'h0);
    #1 rst_n = 1'b1;
    tick();
    check("after_rst_ready", ready, 1'b1);

    // Wide instance: no zero register, 16 entries
    b_rd = 4'd0; b_write_data = 64'hFFFF_FFFF_0000_0001; b_reg_write = 1'b1;
    tick();
    b_reg_write = 1'b0; b_rs1 = 4'd0; b_rs2 = 4'd0;
    #1;
    check("wide_r0_rd1", b_read_data1, 64'hFFFF_FFFF_0000_0001);
    check("wide_r0_rd2", b_read_data2, 64'hFFFF_FFFF_0000_0001);
    b_issue_valid = 1'b1; b_issue_rd = 4'd0;
    tick();
    b_issue_valid = 1'b0;
    #1;
    check("wide_pend0", b_rs1_pend, 1'b1);
    b_scrub_req = 1'b1;
    tick();
    b_scrub_req = 1'b0;
    n = 0;
    for (int unsigned g = 0; g < 64 && b_ready == 1'b0; g++) begin
      n++;
      tick();
    end
    check("wide_scrub_len16", n, 16);
    #1;
    check("wide_r0_scrubbed", b_read_data1, 64'h0);
    check("wide_pend0_cleared", b_rs1_pend, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
